// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_master_arbiter
// Two-master Wishbone B4 pipelined arbiter with a bus watchdog.
// Rev    : 1.0
// ============================================================================
module wb_master_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [3:0]  i_m0_sel,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [3:0]  i_m1_sel,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_timeout,
    output logic [31:0] o_timeout_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [15:0] c_term = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic [31:0] r_timeout_addr;

    logic w_gnt;
    logic w_own_cyc;
    logic w_oth_cyc;
    logic w_term;
    logic w_pick;

    assign w_gnt     = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_own_cyc = r_owner ? i_m1_cyc : i_m0_cyc;
    assign w_oth_cyc = r_owner ? i_m0_cyc : i_m1_cyc;
    // A master that has already dropped cyc is released, not errored.
    assign w_term    = w_gnt && w_own_cyc && !i_wb_ack && (r_cnt == c_term);
    assign w_pick    = (i_m0_cyc && i_m1_cyc) ? ((FIXED_PRIORITY != 0) ? 1'b0 : ~r_last)
                                              : ~i_m0_cyc;

    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        o_m0_stall = 1'b1;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_data  = '0;
        o_m1_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_data  = '0;
        if (w_gnt) begin
            o_m0_data = i_wb_data;
            o_m1_data = i_wb_data;
            if (r_owner) begin
                o_wb_cyc   = i_m1_cyc;
                o_wb_stb   = i_m1_stb;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_wb_sel   = i_m1_sel;
                o_m1_stall = i_wb_stall;
                o_m1_ack   = i_wb_ack;
                o_m1_err   = w_term;
            end else begin
                o_wb_cyc   = i_m0_cyc;
                o_wb_stb   = i_m0_stb;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_wb_sel   = i_m0_sel;
                o_m0_stall = i_wb_stall;
                o_m0_ack   = i_wb_ack;
                o_m0_err   = w_term;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_last         <= 1'b1;
            r_cnt          <= '0;
            r_timeout      <= 1'b0;
            r_timeout_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_m0_cyc || i_m1_cyc) begin
                        r_owner <= w_pick;
                        r_state <= w_pick ? S_GNT1 : S_GNT0;
                    end
                end
                default: begin
                    if (!w_own_cyc) begin
                        // Owner finished: hand straight over if the other master waits.
                        r_last <= r_owner;
                        r_cnt  <= '0;
                        if (w_oth_cyc) begin
                            r_owner <= ~r_owner;
                            r_state <= r_owner ? S_GNT0 : S_GNT1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_state != S_ABORT) begin
                        if (i_wb_ack) begin
                            r_cnt <= '0;
                        end else if (w_term) begin
                            r_state        <= S_ABORT;
                            r_timeout      <= 1'b1;
                            r_timeout_addr <= o_wb_addr;
                        end else if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_timeout      = r_timeout;
    assign o_timeout_addr = r_timeout_addr;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_master_arbiter
// Self-checking bench: round-robin (timeout 8) and fixed-priority instances.
// Rev    : 1.0
// ============================================================================
module tb_wb_master_arbiter;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_cyc [2];
    logic        r_stb [2];
    logic        r_we  [2];
    logic [31:0] r_adr [2];
    logic [31:0] r_dat [2];
    logic [3:0]  r_sel [2];
    logic        r_wstall;
    logic        r_wack;
    logic [31:0] r_wdat;

    wire         w_cyc [2];
    wire         w_stb [2];
    wire         w_we  [2];
    wire  [31:0] w_adr [2];
    wire  [31:0] w_dat [2];
    wire  [3:0]  w_sel [2];
    wire  [1:0]  w_stall [2];
    wire  [1:0]  w_ack [2];
    wire  [1:0]  w_err [2];
    wire  [31:0] w_rd0 [2];
    wire  [31:0] w_rd1 [2];
    wire         w_to  [2];
    wire  [31:0] w_toa [2];

    int total = 0;
    int bad   = 0;

    always #5 r_clk = ~r_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_master_arbiter #(
            .FIXED_PRIORITY(g),
            .TIMEOUT_CYCLES(g == 0 ? 8 : 1024)
        ) u_dut (
            .i_clk(r_clk), .i_rst(r_rst),
            .i_m0_cyc(r_cyc[0]), .i_m0_stb(r_stb[0]), .i_m0_we(r_we[0]),
            .i_m0_addr(r_adr[0]), .i_m0_data(r_dat[0]), .i_m0_sel(r_sel[0]),
            .o_m0_stall(w_stall[g][0]), .o_m0_ack(w_ack[g][0]), .o_m0_err(w_err[g][0]),
            .o_m0_data(w_rd0[g]),
            .i_m1_cyc(r_cyc[1]), .i_m1_stb(r_stb[1]), .i_m1_we(r_we[1]),
            .i_m1_addr(r_adr[1]), .i_m1_data(r_dat[1]), .i_m1_sel(r_sel[1]),
            .o_m1_stall(w_stall[g][1]), .o_m1_ack(w_ack[g][1]), .o_m1_err(w_err[g][1]),
            .o_m1_data(w_rd1[g]),
            .o_wb_cyc(w_cyc[g]), .o_wb_stb(w_stb[g]), .o_wb_we(w_we[g]),
            .o_wb_addr(w_adr[g]), .o_wb_data(w_dat[g]), .o_wb_sel(w_sel[g]),
            .i_wb_stall(r_wstall), .i_wb_ack(r_wack), .i_wb_data(r_wdat),
            .o_timeout(w_to[g]), .o_timeout_addr(w_toa[g])
        );
    end

    task automatic clear_inputs();
        for (int m = 0; m < 2; m++) begin
            r_cyc[m] = 1'b0; r_stb[m] = 1'b0; r_we[m] = 1'b0;
            r_adr[m] = '0;   r_dat[m] = '0;   r_sel[m] = '0;
        end
        r_wstall = 1'b0; r_wack = 1'b0; r_wdat = '0;
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        r_rst = 1'b1;
        clear_inputs();
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({w_cyc[k], w_stb[k], w_we[k], w_adr[k], w_dat[k], w_sel[k]} !== 71'd0) begin
                bad++; $display("FAIL reset_bus[%0d] got cyc=%b adr=%h exp all zero", k, w_cyc[k], w_adr[k]);
            end
            total++;
            if ({w_stall[k], w_ack[k], w_err[k], w_rd0[k], w_rd1[k]} !== {2'b11, 4'b0000, 64'd0}) begin
                bad++; $display("FAIL reset_resp[%0d] got stall=%b ack=%b err=%b exp stall=11", k, w_stall[k], w_ack[k], w_err[k]);
            end
            total++;
            if ({w_to[k], w_toa[k]} !== 33'd0) begin
                bad++; $display("FAIL reset_timeout[%0d] got to=%b addr=%h exp 0", k, w_to[k], w_toa[k]);
            end
        end
    endtask

    task automatic test_single_master();
        do_reset();
        @(negedge r_clk);
        r_cyc[0] = 1'b1; r_stb[0] = 1'b1; r_adr[0] = 32'h0000_0800; r_sel[0] = 4'hF;
        #1 total++;
        if (w_cyc[0] !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", w_cyc[0]); end
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_stb[0], w_we[0], w_adr[0], w_stall[0][1]} !== {3'b110, 32'h0000_0800, 1'b1}) begin
            bad++; $display("FAIL single_grant got cyc=%b adr=%h m1stall=%b exp 1/00000800/1", w_cyc[0], w_adr[0], w_stall[0][1]);
        end
        @(negedge r_clk);
        r_stb[0] = 1'b0;
        #1 total++;
        if ({w_ack[0][0], w_stall[0][1]} !== 2'b01) begin
            bad++; $display("FAIL single_wait got ack=%b m1stall=%b exp 0/1", w_ack[0][0], w_stall[0][1]);
        end
        @(negedge r_clk);
        r_wack = 1'b1; r_wdat = 32'h1234_5678;
        #1 total++;
        if ({w_ack[0][0], w_rd0[0], w_stall[0][1], w_ack[0][1]} !== {1'b1, 32'h1234_5678, 2'b10}) begin
            bad++; $display("FAIL single_ack got ack=%b data=%h m1stall=%b m1ack=%b", w_ack[0][0], w_rd0[0], w_stall[0][1], w_ack[0][1]);
        end
        @(negedge r_clk);
        r_wack = 1'b0; r_cyc[0] = 1'b0;
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_stall[0]} !== 3'b011) begin
            bad++; $display("FAIL single_release got cyc=%b stall=%b exp 0/11", w_cyc[0], w_stall[0]);
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        @(negedge r_clk);
        for (int m = 0; m < 2; m++) begin r_cyc[m] = 1'b1; r_stb[m] = 1'b1; end
        r_adr[0] = 32'hA000_0000; r_adr[1] = 32'hB000_0000;
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_adr[0], w_stall[0]} !== {1'b1, 32'hA000_0000, 2'b10}) begin
            bad++; $display("FAIL tie_first got cyc=%b adr=%h stall=%b exp m0", w_cyc[0], w_adr[0], w_stall[0]);
        end
        @(negedge r_clk);
        r_cyc[0] = 1'b0; r_stb[0] = 1'b0;
        #1 total++;
        if (w_cyc[0] !== 1'b0) begin bad++; $display("FAIL tie_gap got cyc=%b exp=0", w_cyc[0]); end
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_adr[0], w_stall[0]} !== {1'b1, 32'hB000_0000, 2'b01}) begin
            bad++; $display("FAIL tie_handover got cyc=%b adr=%h stall=%b exp m1", w_cyc[0], w_adr[0], w_stall[0]);
        end
        @(negedge r_clk);
        clear_inputs();
    endtask

    task automatic test_contention();
        int  seq[$];
        int  held[2];
        int  rem[2];
        bit  drop[2];
        bit  prev;
        int  gc;
        do_reset();
        r_adr[0] = 32'h1000_0000; r_adr[1] = 32'h1000_0001;
        held = '{0, 0}; rem = '{4, 4}; drop = '{1'b0, 1'b0}; prev = 1'b0;
        for (int c = 0; c < 60 && seq.size() < 8; c++) begin
            @(negedge r_clk);
            for (int m = 0; m < 2; m++) begin
                if (drop[m]) begin
                    r_cyc[m] = 1'b0; drop[m] = 1'b0; held[m] = 0;
                end else if (!r_cyc[m] && rem[m] > 0) begin
                    r_cyc[m] = 1'b1;
                end
                r_stb[m] = r_cyc[m];
            end
            #1;
            if (w_cyc[0]) begin
                gc = (w_adr[0] == 32'h1000_0001) ? 1 : 0;
                if (!prev) begin seq.push_back(gc); rem[gc]--; end
                held[gc]++;
                if (held[gc] == 2) drop[gc] = 1'b1;
            end
            prev = w_cyc[0];
        end
        total++;
        if (seq.size() != 8) begin bad++; $display("FAIL contention_count got=%0d exp=8", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (seq[i] != i % 2) begin bad++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, seq[i], i % 2); end
        end
        @(negedge r_clk);
        clear_inputs();
    endtask

    task automatic test_watchdog();
        logic [8:1] errs;
        do_reset();
        @(negedge r_clk);
        r_cyc[1] = 1'b1; r_stb[1] = 1'b1; r_we[1] = 1'b1; r_adr[1] = 32'h7000_0000;
        r_dat[1] = 32'hDEAD_BEEF; r_sel[1] = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge r_clk); #1;
            errs[i] = w_err[0][1];
            if (i == 8) begin
                total++;
                if ({w_cyc[0], w_we[0], w_dat[0]} !== {2'b11, 32'hDEAD_BEEF}) begin
                    bad++; $display("FAIL wd_fwd got cyc=%b we=%b data=%h", w_cyc[0], w_we[0], w_dat[0]);
                end
            end
        end
        total++;
        if (errs !== 8'b1000_0000) begin bad++; $display("FAIL wd_err_pulse got=%b exp=10000000", errs); end
        for (int i = 0; i < 3; i++) begin
            @(negedge r_clk); #1 total++;
            if ({w_cyc[0], w_stb[0], w_stall[0][1], w_err[0][1], w_to[0], w_toa[0]} !== {4'b0010, 1'b1, 32'h7000_0000}) begin
                bad++; $display("FAIL wd_abort got cyc=%b stall=%b to=%b toa=%h exp 0/1/1/70000000", w_cyc[0], w_stall[0][1], w_to[0], w_toa[0]);
            end
        end
        @(negedge r_clk);
        r_cyc[1] = 1'b0; r_stb[1] = 1'b0;
        r_cyc[0] = 1'b1; r_stb[0] = 1'b1; r_adr[0] = 32'h0000_0100;
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_adr[0], w_stall[0][0]} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            bad++; $display("FAIL wd_next_grant got cyc=%b adr=%h stall=%b", w_cyc[0], w_adr[0], w_stall[0][0]);
        end
        @(negedge r_clk);
        r_stb[0] = 1'b0; r_wack = 1'b1; r_wdat = 32'h0000_0055;
        #1 total++;
        if ({w_ack[0][0], w_err[0][0], w_rd0[0]} !== {2'b10, 32'h0000_0055}) begin
            bad++; $display("FAIL wd_next_ack got ack=%b err=%b data=%h", w_ack[0][0], w_err[0][0], w_rd0[0]);
        end
        @(negedge r_clk);
        clear_inputs();
    endtask

    task automatic test_ack_boundary();
        bit any_err;
        do_reset();
        @(negedge r_clk);
        r_cyc[0] = 1'b1; r_stb[0] = 1'b1; r_adr[0] = 32'h0000_0200;
        for (int i = 1; i <= 8; i++) begin
            @(negedge r_clk);
            r_wack = (i == 8);
            #1;
            if (i == 8) begin
                total++;
                if ({w_ack[0][0], w_err[0][0]} !== 2'b10) begin
                    bad++; $display("FAIL boundary_ack got ack=%b err=%b exp 1/0", w_ack[0][0], w_err[0][0]);
                end
            end
        end
        any_err = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge r_clk);
            r_wack = 1'b0;
            #1 any_err |= w_err[0][0];
        end
        total++;
        if ({any_err, w_to[0], w_cyc[0]} !== 3'b001) begin
            bad++; $display("FAIL boundary_restart got err=%b to=%b cyc=%b exp 0/0/1", any_err, w_to[0], w_cyc[0]);
        end
        @(negedge r_clk); #1 total++;
        if (w_err[0][0] !== 1'b1) begin bad++; $display("FAIL boundary_recount got err=%b exp=1", w_err[0][0]); end
    endtask

    task automatic test_reset_mid();
        @(negedge r_clk);
        clear_inputs();
        @(negedge r_clk);
        r_cyc[0] = 1'b1; r_stb[0] = 1'b1; r_adr[0] = 32'h0000_0300;
        @(negedge r_clk); #1 total++;
        if (w_cyc[0] !== 1'b1) begin bad++; $display("FAIL rstmid_grant got cyc=%b exp=1", w_cyc[0]); end
        @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        r_rst = 1'b0; r_cyc[0] = 1'b0; r_stb[0] = 1'b0;
        #1 total++;
        if ({w_cyc[0], w_stb[0], w_we[0], w_adr[0], w_dat[0], w_sel[0], w_stall[0], w_ack[0], w_err[0], w_to[0], w_toa[0]}
            !== {71'd0, 2'b11, 4'b0000, 33'd0}) begin
            bad++; $display("FAIL rstmid_outputs got cyc=%b stall=%b to=%b toa=%h", w_cyc[0], w_stall[0], w_to[0], w_toa[0]);
        end
        @(negedge r_clk);
        for (int m = 0; m < 2; m++) begin r_cyc[m] = 1'b1; r_stb[m] = 1'b1; end
        r_adr[0] = 32'h0000_0400; r_adr[1] = 32'h0000_0500;
        @(negedge r_clk); #1 total++;
        if ({w_cyc[0], w_adr[0]} !== {1'b1, 32'h0000_0400}) begin
            bad++; $display("FAIL rstmid_tie got cyc=%b adr=%h exp m0", w_cyc[0], w_adr[0]);
        end
        @(negedge r_clk);
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        @(negedge r_clk);
        r_cyc[0] = 1'b1; r_stb[0] = 1'b1; r_adr[0] = 32'h0000_0600; r_adr[1] = 32'h0000_0700;
        @(negedge r_clk);
        @(negedge r_clk);
        r_cyc[0] = 1'b0; r_stb[0] = 1'b0;
        @(negedge r_clk);
        for (int m = 0; m < 2; m++) begin r_cyc[m] = 1'b1; r_stb[m] = 1'b1; end
        @(negedge r_clk); #1 total++;
        if (w_adr[0] !== 32'h0000_0700) begin bad++; $display("FAIL rr_second_tie got adr=%h exp=00000700", w_adr[0]); end
        total++;
        if ({w_adr[1], w_stall[1][1]} !== {32'h0000_0600, 1'b1}) begin
            bad++; $display("FAIL fixed_second_tie got adr=%h m1stall=%b exp 00000600/1", w_adr[1], w_stall[1][1]);
        end
        @(negedge r_clk);
        clear_inputs();
    endtask

    task automatic test_random();
        int          tt[2]    = '{8, 1024};
        int          mg[2];
        bit          mabt[2];
        int          mlast[2];
        int          mwd[2];
        bit          mto[2];
        logic [31:0] mtoa[2];
        int          o;
        bit          gr;
        logic [70:0] eb;
        logic [1:0]  est;
        logic [1:0]  eak;
        logic [1:0]  eer;
        logic [31:0] erd;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mg[k] = -1; mabt[k] = 1'b0; mlast[k] = 1; mwd[k] = 0; mto[k] = 1'b0; mtoa[k] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge r_clk);
            r_rst = ($urandom_range(99) == 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(4) == 0) r_cyc[m] = ~r_cyc[m];
                r_stb[m] = 1'($urandom());
                r_we[m]  = 1'($urandom());
                r_adr[m] = $urandom();
                r_dat[m] = $urandom();
                r_sel[m] = 4'($urandom());
            end
            r_wack   = ($urandom_range(3) == 0);
            r_wstall = 1'($urandom());
            r_wdat   = $urandom();
            #1;
            for (int k = 0; k < 2; k++) begin
                gr  = (mg[k] >= 0) && !mabt[k];
                o   = (mg[k] < 0) ? 0 : mg[k];
                eb  = gr ? {r_cyc[o], r_stb[o], r_we[o], r_adr[o], r_dat[o], r_sel[o]} : 71'd0;
                erd = gr ? r_wdat : 32'd0;
                for (int m = 0; m < 2; m++) begin
                    est[m] = (gr && o == m) ? r_wstall : 1'b1;
                    eak[m] = (gr && o == m) ? r_wack : 1'b0;
                    eer[m] = gr && o == m && r_cyc[m] && !r_wack && (mwd[k] == tt[k] - 1);
                end
                total++;
                if ({w_cyc[k], w_stb[k], w_we[k], w_adr[k], w_dat[k], w_sel[k]} !== eb) begin
                    bad++; $display("FAIL rnd_bus[%0d] cycle=%0d got cyc=%b adr=%h exp cyc=%b adr=%h", k, c, w_cyc[k], w_adr[k], eb[70], eb[67:36]);
                end
                total++;
                if ({w_stall[k], w_ack[k], w_err[k], w_rd0[k], w_rd1[k]} !== {est, eak, eer, erd, erd}) begin
                    bad++; $display("FAIL rnd_resp[%0d] cycle=%0d got stall=%b ack=%b err=%b exp stall=%b ack=%b err=%b", k, c, w_stall[k], w_ack[k], w_err[k], est, eak, eer);
                end
                total++;
                if ({w_to[k], w_toa[k]} !== {mto[k], mtoa[k]}) begin
                    bad++; $display("FAIL rnd_timeout[%0d] cycle=%0d got to=%b toa=%h exp to=%b toa=%h", k, c, w_to[k], w_toa[k], mto[k], mtoa[k]);
                end
                if (r_rst) begin
                    mg[k] = -1; mabt[k] = 1'b0; mlast[k] = 1; mwd[k] = 0; mto[k] = 1'b0; mtoa[k] = '0;
                end else if (mg[k] < 0) begin
                    if (r_cyc[0] && r_cyc[1]) mg[k] = (k == 1) ? 0 : 1 - mlast[k];
                    else if (r_cyc[0])        mg[k] = 0;
                    else if (r_cyc[1])        mg[k] = 1;
                    mwd[k] = 0;
                end else if (!r_cyc[o]) begin
                    mlast[k] = o;
                    mg[k]    = r_cyc[1 - o] ? 1 - o : -1;
                    mabt[k]  = 1'b0;
                    mwd[k]   = 0;
                end else if (!mabt[k]) begin
                    if (r_wack) begin
                        mwd[k] = 0;
                    end else if (mwd[k] == tt[k] - 1) begin
                        mabt[k] = 1'b1; mto[k] = 1'b1; mtoa[k] = r_adr[o];
                    end else begin
                        mwd[k] = mwd[k] + 1;
                    end
                end
            end
        end
        @(negedge r_clk);
        r_rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        r_rst = 1'b1;
        test_reset();
        test_single_master();
        test_tie_handover();
        test_contention();
        test_watchdog();
        test_ack_boundary();
        test_reset_mid();
        test_fixed_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
